dmem_wait_ctrl: RTL and testbench

Wait-state data-memory controller sitting directly downstream of the single-cycle MIPS core, replacing the zero-latency data memory. Accepts the core's lw/sw request (address, write data, read/write strobes), holds an internal word RAM with a fixed programmable access latency, and returns a `stall` that freezes the core's PC and register-file write until the access completes. It also flags misaligned, out-of-range and contradictory requests.

---
 rtl/dmem_pkg.sv | 12 +
 rtl/dmem_wait_ctrl_wsram.sv | 23 ++
 rtl/dmem_wait_ctrl.sv | 94 +++++++++
 tb/tb_dmem_wait_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared types, constants and request checking for the wait-state data memory
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    localparam int LAT_W = 4;

    function automatic logic req_legal(input logic rd, input logic wr, input logic [31:0] addr, input int depth);
        return (rd ^ wr) && (addr[1:0] == 2'b00) && ({2'b00, addr[31:2]} < 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_wait_ctrl_wsram.sv
// wsram: word RAM with one registered write port and one combinational read port, never cleared
module wsram #(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    // write commits on the clock edge ending the write cycle
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/dmem_wait_ctrl.sv
// dmem_wait_ctrl: wait-state data memory controller that stalls the core for a fixed latency
module dmem_wait_ctrl
    import dmem_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int LAT   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err,
    output logic [15:0] acc_cnt
);

    localparam int AW = $clog2(DEPTH);

    state_t           state, next_state;
    logic [LAT_W-1:0] cnt;
    logic [AW-1:0]    idx, req_idx, ram_addr;
    logic [31:0]      wdat, ram_wdata, ram_rd, rdata_q;
    logic             is_wr, legal, accept, lat0_rd, lat0_wr, cap, we, done_acc;

    assign req_idx = req_addr[AW+1:2];

    wsram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ram_addr),
        .wdata (ram_wdata),
        .raddr (ram_addr),
        .rdata (ram_rd)
    );

    // request decode; in IDLE the RAM is addressed by the live request, afterwards by the latched one
    always_comb begin
        legal     = req_legal(req_rd, req_wr, req_addr, DEPTH);
        accept    = state == IDLE && legal && LAT != 0;
        lat0_rd   = state == IDLE && legal && LAT == 0 && req_rd;
        lat0_wr   = state == IDLE && legal && LAT == 0 && req_wr;
        cap       = lat0_rd || (accept && LAT == 1 && req_rd) || (state == WAIT && cnt == LAT_W'(1) && !is_wr);
        we        = reset && (lat0_wr || (state == DONE && is_wr));
        done_acc  = lat0_rd || lat0_wr || state == DONE;
        ram_addr  = state == IDLE ? req_idx : idx;
        ram_wdata = state == IDLE ? req_wdata : wdat;
    end

    // state register
    always_ff @(posedge clk) begin
        if (!reset) state <= IDLE;
        else state <= next_state;
    end

    // counter holds LAT-1 after acceptance and reaches 0 as DONE is entered; LAT=1 skips WAIT
    always_comb begin
        next_state = state == IDLE ? (accept ? (LAT == 1 ? DONE : WAIT) : IDLE)
                   : state == WAIT ? (cnt == LAT_W'(1) ? DONE : WAIT)
                   : IDLE;
    end

    // outputs; status strobes are held low while reset is asserted
    always_comb begin
        stall  = reset && (accept || state == WAIT);
        rvalid = reset && (lat0_rd || (state == DONE && !is_wr));
        err    = reset && state == IDLE && (req_rd || req_wr) && !legal;
        rdata  = lat0_rd ? ram_rd : rdata_q;
    end

    // latch the accepted request, run the wait counter, capture read data and count completions
    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt     <= '0;
            rdata_q <= '0;
            acc_cnt <= '0;
        end else begin
            if (accept) begin
                idx   <= req_idx;
                wdat  <= req_wdata;
                is_wr <= req_wr;
                cnt   <= LAT_W'(LAT - 1);
            end else if (state == WAIT) begin
                cnt <= cnt - LAT_W'(1);
            end
            if (cap) rdata_q <= ram_rd;
            if (done_acc) acc_cnt <= acc_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_dmem_wait_ctrl.sv
// tb_dmem_wait_ctrl: five controllers at different latencies checked against a transaction-level model
module tb_dmem_wait_ctrl;

    localparam int ND = 5;

    function automatic int lat_of(input int k);
        return k == 0 ? 2 : k == 1 ? 0 : k == 2 ? 3 : k == 3 ? 4 : 1;
    endfunction

    logic        clk = 1'b0;
    logic        rst_n [ND];
    logic        rd [ND], wr [ND];
    logic [31:0] addr [ND], wd [ND], rdat [ND];
    logic        stl [ND], rv [ND], er [ND];
    logic [15:0] acc [ND];

    logic        e_stall [ND], e_rv [ND], e_err [ND];
    logic [31:0] e_rdata [ND];
    logic [15:0] e_acc [ND];

    logic [31:0] mem_m [ND][64];
    logic [31:0] last [ND];
    logic [15:0] macc [ND];

    int  n_chk = 0;
    int  n_fail = 0;
    logic chk_on = 1'b0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : gd
        dmem_wait_ctrl #(.DEPTH(64), .LAT(lat_of(g))) u_dut (
            .clk       (clk),
            .reset     (rst_n[g]),
            .req_rd    (rd[g]),
            .req_wr    (wr[g]),
            .req_addr  (addr[g]),
            .req_wdata (wd[g]),
            .stall     (stl[g]),
            .rdata     (rdat[g]),
            .rvalid    (rv[g]),
            .err       (er[g]),
            .acc_cnt   (acc[g])
        );
    end

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] ev);
        n_chk++;
        if (act !== ev) begin
            n_fail++;
            $display("FAIL %s dut%0d (LAT=%0d) t=%0t: got %h expected %h", nm, k, lat_of(k), $time, act, ev);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            for (int k = 0; k < ND; k++) begin
                chk("stall", k, 32'(stl[k]), 32'(e_stall[k]));
                chk("rvalid", k, 32'(rv[k]), 32'(e_rv[k]));
                chk("err", k, 32'(er[k]), 32'(e_err[k]));
                chk("rdata", k, rdat[k], e_rdata[k]);
                chk("acc_cnt", k, 32'(acc[k]), 32'(e_acc[k]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle(input int k);
        rd[k] = 1'b0;
        wr[k] = 1'b0;
        e_stall[k] = 1'b0;
        e_rv[k] = 1'b0;
        e_err[k] = 1'b0;
        e_rdata[k] = last[k];
        e_acc[k] = macc[k];
    endtask

    task automatic access(input int k, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
        int   n;
        logic ok;
        n  = lat_of(k);
        ok = (r ^ w) && (a % 4 == 0) && (a / 4 < 64);
        rd[k] = r;
        wr[k] = w;
        addr[k] = a;
        wd[k] = d;
        set_idle(k);
        rd[k] = r;
        wr[k] = w;
        if (!ok) begin
            e_err[k] = 1'b1;
            step();
            set_idle(k);
            return;
        end
        for (int c = 0; c < n; c++) begin
            e_stall[k] = 1'b1;
            step();
            addr[k] = a ^ 32'h4;
            wd[k] = ~d;
        end
        e_stall[k] = 1'b0;
        e_rv[k] = r;
        if (r) e_rdata[k] = mem_m[k][a[7:2]];
        step();
        if (w) mem_m[k][a[7:2]] = d;
        if (r) last[k] = mem_m[k][a[7:2]];
        macc[k] = macc[k] + 16'd1;
        set_idle(k);
    endtask

    initial begin
        for (int k = 0; k < ND; k++) begin
            rst_n[k] = 1'b0;
            addr[k] = '0;
            wd[k] = '0;
            last[k] = '0;
            macc[k] = '0;
            set_idle(k);
        end
        @(posedge clk);
        #1;
        chk_on = 1'b1;
        step();
        for (int k = 0; k < ND; k++) rst_n[k] = 1'b1;
        step();

        access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("lit_lat2_rdata", 0, rdat[0], 32'hDEADBEEF);
        chk("lit_lat2_acc", 0, 32'(acc[0]), 32'd2);
        access(0, 1'b1, 1'b0, 32'h6, 32'h0);
        access(0, 1'b0, 1'b1, 32'h100, 32'h55555555);
        access(0, 1'b1, 1'b1, 32'h10, 32'h66666666);
        chk("lit_illegal_acc", 0, 32'(acc[0]), 32'd2);
        access(0, 1'b1, 1'b0, 32'h10, 32'h0);
        chk("lit_illegal_ram", 0, rdat[0], 32'hDEADBEEF);

        access(1, 1'b0, 1'b1, 32'h4, 32'h12345678);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);
        chk("lit_lat0_rdata", 1, rdat[1], 32'h12345678);

        access(2, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D);
        access(2, 1'b0, 1'b1, 32'h24, 32'h0BADF00D);
        access(2, 1'b1, 1'b0, 32'h20, 32'h0);
        chk("lit_lat3_word8", 2, rdat[2], 32'hCAFEF00D);

        access(3, 1'b0, 1'b1, 32'h8, 32'h11112222);
        rd[3] = 1'b0;
        wr[3] = 1'b1;
        addr[3] = 32'h8;
        wd[3] = 32'hAAAA5555;
        e_stall[3] = 1'b1;
        step();
        step();
        rst_n[3] = 1'b0;
        e_stall[3] = 1'b0;
        step();
        rst_n[3] = 1'b1;
        last[3] = '0;
        macc[3] = '0;
        set_idle(3);
        step();
        chk("lit_reset_acc", 3, 32'(acc[3]), 32'd0);
        access(3, 1'b1, 1'b0, 32'h8, 32'h0);
        chk("lit_reset_ram", 3, rdat[3], 32'h11112222);

        for (int i = 0; i < 16; i++) access(4, 1'b0, 1'b1, 32'(i * 4), 32'(i) * 32'h01010101 + 32'd7);
        for (int i = 15; i >= 0; i--) access(4, 1'b1, 1'b0, 32'(i * 4), 32'h0);
        chk("lit_lat1_rdata", 4, rdat[4], 32'd7);

        for (int i = 0; i < 65534; i++) access(1, 1'(i & 1), 1'(~i & 1), 32'(((i >> 1) % 64) * 4), 32'(i));
        chk("lit_wrap_acc", 1, 32'(acc[1]), 32'd0);
        access(1, 1'b1, 1'b0, 32'h4, 32'h0);
        chk("lit_wrap_acc1", 1, 32'(acc[1]), 32'd1);

        step();
        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
